// File: rtl/upload_frame_packer.sv
// Serialises one response frame (AA 44 CMD LENH LENL payload CHK) onto the USB upload byte port.
// Define UPLOAD_CRC8_EN to replace the modulo-sum CHK with CRC-8 (poly 0x07, init 0x00).
module upload_frame_packer #(
    parameter logic [7:0] HDR0           = 8'hAA,
    parameter logic [7:0] HDR1           = 8'h44,
    parameter int         MAX_LEN        = 1024,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [15:0] req_len,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    input  logic        upload_afull,
    output logic [7:0]  upload_data,
    output logic        upload_valid,
    output logic        busy,
    output logic        err_trunc,
    output logic        err_timeout
);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int REM_W = $clog2(MAX_LEN + 1);
    localparam logic [15:0]      MAX_LEN_16 = 16'(MAX_LEN);
    localparam logic [TMR_W-1:0] TMO_FULL   = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMO_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_H0, S_H1, S_CMD, S_LENH, S_LENL, S_PAYLOAD, S_CHK
    } state_t;

    state_t           state;
    logic [7:0]       cmd_q;
    logic [15:0]      len_q;
    logic [REM_W-1:0] rem;
    logic [7:0]       chk;
    logic [TMR_W-1:0] tmr;
    logic             pad;
    logic             accept;
    logic             pl_fire;

    function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
`ifdef UPLOAD_CRC8_EN
        logic [7:0] c;
        c = acc ^ b;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        return c;
`else
        return acc + b;
`endif
    endfunction

    assign accept    = req_valid & req_ready;
    assign err_trunc = accept & (req_len > MAX_LEN_16);
    // Once padding starts the source is no longer consulted for this frame.
    assign pl_ready  = (state == S_PAYLOAD) & ~upload_afull & ~pad;
    assign pl_fire   = pl_valid & pl_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            req_ready    <= 1'b0;
            busy         <= 1'b0;
            upload_data  <= 8'h00;
            upload_valid <= 1'b0;
            err_timeout  <= 1'b0;
            cmd_q        <= 8'h00;
            len_q        <= 16'h0000;
            rem          <= '0;
            chk          <= 8'h00;
            tmr          <= '0;
            pad          <= 1'b0;
        end else begin
            upload_valid <= 1'b0;
            err_timeout  <= 1'b0;
            case (state)
                S_IDLE: begin
                    // busy stays high through the CHK byte cycle, then drops here.
                    if (accept) begin
                        state     <= S_H0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        cmd_q     <= req_cmd;
                        len_q     <= (req_len > MAX_LEN_16) ? MAX_LEN_16 : req_len;
                        chk       <= 8'h00;
                        tmr       <= '0;
                        pad       <= 1'b0;
                    end else begin
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                S_H0: if (!upload_afull) begin
                    upload_data  <= HDR0;
                    upload_valid <= 1'b1;
                    state        <= S_H1;
                end
                S_H1: if (!upload_afull) begin
                    upload_data  <= HDR1;
                    upload_valid <= 1'b1;
                    state        <= S_CMD;
                end
                S_CMD: if (!upload_afull) begin
                    upload_data  <= cmd_q;
                    upload_valid <= 1'b1;
                    chk          <= chk_next(chk, cmd_q);
                    state        <= S_LENH;
                end
                S_LENH: if (!upload_afull) begin
                    upload_data  <= len_q[15:8];
                    upload_valid <= 1'b1;
                    chk          <= chk_next(chk, len_q[15:8]);
                    state        <= S_LENL;
                end
                S_LENL: if (!upload_afull) begin
                    upload_data  <= len_q[7:0];
                    upload_valid <= 1'b1;
                    chk          <= chk_next(chk, len_q[7:0]);
                    rem          <= REM_W'(len_q);
                    state        <= (len_q == 16'd0) ? S_CHK : S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    if (pad) begin
                        if (!upload_afull) begin
                            upload_data  <= 8'h00;
                            upload_valid <= 1'b1;
                            chk          <= chk_next(chk, 8'h00);
                            rem          <= rem - 1'b1;
                            if (rem == REM_W'(1)) state <= S_CHK;
                        end
                    end else if (pl_fire) begin
                        upload_data  <= pl_data;
                        upload_valid <= 1'b1;
                        chk          <= chk_next(chk, pl_data);
                        rem          <= rem - 1'b1;
                        tmr          <= '0;
                        if (rem == REM_W'(1)) state <= S_CHK;
                    end else if (!pl_valid && !upload_afull) begin
                        if (tmr == TMO_LAST) begin
                            tmr         <= TMO_FULL;
                            err_timeout <= 1'b1;
                            pad         <= 1'b1;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                end
                S_CHK: if (!upload_afull) begin
                    upload_data  <= chk;
                    upload_valid <= 1'b1;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
